sd4_mac_ctrl: RTL and testbench
===============================

// Module: sd4_mac_ctrl
// PURPOSE
//  Sequencer for one SD4 MAC dot-product. Accepts a stream of signed products with exponents and
//  aligns each one to the running maximum exponent. Accumulates the stream into a 20-bit signed sum.
//  Hands {sum, exp_max} to the normalization instance and registers its result. Presents the
//  result on a valid/ready output port. Sits between the SD4 multiplier array and the FP result writer.
// PARAMETERS
//  ACC_W   20  accumulator / nrm_signed_sum width (fixed by the normalization datapath)
//  EXP_W   6   input exponent width, signed
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   synchronous reset, active-high
//  in_valid        in   1   product term valid
//  in_ready        out  1   controller can accept a term
//  in_prod         in   20  signed product, same fixed-point format as signed_sum
//  in_exp          in   6   signed exponent of in_prod
//  in_last         in   1   final term of the dot-product
//  nrm_signed_sum  out  20  to normalization.signed_sum (the accumulator register)
//  nrm_exp_max     out  6   to normalization.exp_max (the exp_max register)
//  nrm_sign        in   1   from normalization.sign
//  nrm_sum         in   11  from normalization.norm_sum
//  nrm_exp         in   7   from normalization.exp_final, signed
//  out_valid       out  1   result valid
//  out_ready       in   1   downstream accepts result
//  out_sign        out  1   result sign
//  out_mant        out  11  result mantissa
//  out_exp         out  7   result exponent, signed
//  out_zero        out  1   accumulator was exactly 0
//  out_ovf         out  1   sticky: accumulator overflowed during this dot-product
// BEHAVIOUR
//  Reset: every register and every output goes to 0. State goes to IDLE. A reset in any state
//  aborts the operation with no output.
//  FSM:
//   IDLE : in_ready=1. On in_valid: acc<=in_prod, exp_max<=in_exp, ovf<=0.
//          Go to NORM if in_last, else go to ACCUM.
//   ACCUM: in_ready=1. On in_valid, d = in_exp - exp_max (7-bit signed).
//          d>0 : acc <= (acc >>> d) + in_prod; exp_max <= in_exp.
//          d<=0: acc <= acc + (in_prod >>> -d).
//          Shift amounts >=19 give pure sign fill.
//          Signed overflow of the 20-bit add sets ovf (sticky).
//          Stay in ACCUM; go to NORM when in_last.
//   NORM : in_ready=0. Exactly 1 cycle. Capture nrm_sign, nrm_sum, nrm_exp, (acc==0) and ovf
//          into the out_* registers. Go to OUT.
//   OUT  : in_ready=0, out_valid=1. Outputs hold stable until out_ready=1, then go to IDLE.
//          in_ready stays 0 during the handshake cycle.
//  in_valid is ignored when in_ready=0.
//  nrm_* outputs are driven only from registers, so the normalization path is register-to-register.
//  Latency: in_last accepted in cycle T -> out_valid=1 in cycle T+2. Throughput: one term per cycle.
//  A 1-term dot-product is legal (IDLE -> NORM directly).
//  acc==0: the controller passes the normalization result through and sets out_zero=1.
// CONFIGURATION
//  MAC_SAT_EN defined: an overflowing add saturates acc to 0x7FFFF (positive overflow) or 0x80000
//  (negative overflow). ovf is still set.
//  MAC_SAT_EN undefined: the add wraps modulo 2^20 and sets ovf.
// TESTING
//  T1 (1024,e0),(1024,e0,last) -> acc=2048. out_mant=0x400, out_exp=1, sign=0. out_valid 2 cycles after last.
//  T2 (1024,e2),(1024,e0,last) -> acc=1280, exp_max=2. out_mant=0x500, out_exp=2.
//  T3 (1024,e0),(1024,e3,last) -> acc=128+1024=1152, exp_max=3 (acc realigned).
//  T4 (-1024,e0),(1024,e0,last) -> acc=0. out_zero=1, out_mant=0.
//  T5 (0x40000,e0),(0x40000,e0,last) -> out_ovf=1. Wrap: acc=0x80000. MAC_SAT_EN: acc=0x7FFFF.
//  T6 out_ready held 0 for 5 cycles -> outputs stable and in_ready=0. Then rst mid-ACCUM -> all zero, IDLE.

Source files
------------

// File: rtl/sd4_mac_ctrl.sv
// SD4 MAC dot-product sequencer: aligns products to the running max exponent, accumulates into a
// 20-bit signed sum, captures the normalization result and presents it on a valid/ready port.
// Optional feature: define MAC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module sd4_mac_ctrl #(
  parameter int unsigned AccW = 20,
  parameter int unsigned ExpW = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [AccW-1:0] in_prod_i,
  input  logic [ExpW-1:0] in_exp_i,
  input  logic            in_last_i,
  output logic [AccW-1:0] nrm_signed_sum_o,
  output logic [ExpW-1:0] nrm_exp_max_o,
  input  logic            nrm_sign_i,
  input  logic [10:0]     nrm_sum_i,
  input  logic [ExpW:0]   nrm_exp_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            out_sign_o,
  output logic [10:0]     out_mant_o,
  output logic [ExpW:0]   out_exp_o,
  output logic            out_zero_o,
  output logic            out_ovf_o
);

  typedef enum logic [1:0] {StIdle, StAccum, StNorm, StOut} state_e;

  localparam logic [ExpW:0] MaxShift = (ExpW + 1)'(AccW - 1);

  state_e                 state_q, state_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [ExpW-1:0]        exp_q, exp_d;
  logic                   ovf_q, ovf_d;
  logic                   out_load;

  logic                   out_sign_q;
  logic [10:0]            out_mant_q;
  logic [ExpW:0]          out_exp_q;
  logic                   out_zero_q;
  logic                   out_ovf_q;

  // Alignment datapath: the operand with the smaller exponent is shifted right.
  logic signed [ExpW:0]   diff;
  logic [ExpW:0]          shamt_raw;
  logic [ExpW:0]          shamt;
  logic                   align_up;
  logic signed [AccW-1:0] small_op;
  logic signed [AccW-1:0] big_op;
  logic signed [AccW-1:0] small_sh;
  logic signed [AccW-1:0] sum;
  logic                   add_ovf;
  logic signed [AccW-1:0] add_res;

  always_comb begin
    diff      = $signed({in_exp_i[ExpW-1], in_exp_i}) - $signed({exp_q[ExpW-1], exp_q});
    align_up  = (diff > 0);
    shamt_raw = align_up ? diff : -diff;
    shamt     = (shamt_raw >= MaxShift) ? MaxShift : shamt_raw;
    small_op  = align_up ? acc_q : $signed(in_prod_i);
    big_op    = align_up ? $signed(in_prod_i) : acc_q;
    small_sh  = small_op >>> shamt;
    sum       = small_sh + big_op;
    add_ovf   = (small_sh[AccW-1] == big_op[AccW-1]) && (sum[AccW-1] != big_op[AccW-1]);
`ifdef MAC_SAT_EN
    if (add_ovf) begin
      add_res = big_op[AccW-1] ? $signed({1'b1, {(AccW-1){1'b0}}})
                               : $signed({1'b0, {(AccW-1){1'b1}}});
    end else begin
      add_res = sum;
    end
`else
    add_res = sum;
`endif
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    exp_d       = exp_q;
    ovf_d       = ovf_q;
    out_load    = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          acc_d   = $signed(in_prod_i);
          exp_d   = in_exp_i;
          ovf_d   = 1'b0;
          state_d = in_last_i ? StNorm : StAccum;
        end
      end
      StAccum: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          acc_d = add_res;
          exp_d = align_up ? in_exp_i : exp_q;
          ovf_d = ovf_q | add_ovf;
          if (in_last_i) begin
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        out_load = 1'b1;
        state_d  = StOut;
      end
      StOut: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Hold handshake outputs low while reset is asserted.
    if (rst_i) begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      exp_q      <= '0;
      ovf_q      <= 1'b0;
      out_sign_q <= 1'b0;
      out_mant_q <= '0;
      out_exp_q  <= '0;
      out_zero_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      exp_q   <= exp_d;
      ovf_q   <= ovf_d;
      if (out_load) begin
        out_sign_q <= nrm_sign_i;
        out_mant_q <= nrm_sum_i;
        out_exp_q  <= nrm_exp_i;
        out_zero_q <= (acc_q == '0);
        out_ovf_q  <= ovf_q;
      end
    end
  end

  assign nrm_signed_sum_o = acc_q;
  assign nrm_exp_max_o    = exp_q;
  assign out_sign_o       = out_sign_q;
  assign out_mant_o       = out_mant_q;
  assign out_exp_o        = out_exp_q;
  assign out_zero_o       = out_zero_q;
  assign out_ovf_o        = out_ovf_q;

endmodule

// File: tb/tb_sd4_mac_ctrl.sv
// Bench for sd4_mac_ctrl: directed cases plus random dot-products checked against an
// integer-arithmetic model; also plays the normalization block from the nrm_* outputs.
module tb_sd4_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [19:0] in_prod;
  logic [5:0]  in_exp;
  logic [19:0] nrm_signed_sum;
  logic [5:0]  nrm_exp_max;
  logic        nrm_sign;
  logic [10:0] nrm_sum;
  logic [6:0]  nrm_exp;
  logic        out_valid, out_ready, out_sign, out_zero, out_ovf;
  logic [10:0] out_mant;
  logic [6:0]  out_exp;
  logic [18:0] nrm_word;

  always #5 clk = ~clk;

  sd4_mac_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_prod_i        (in_prod),
    .in_exp_i         (in_exp),
    .in_last_i        (in_last),
    .nrm_signed_sum_o (nrm_signed_sum),
    .nrm_exp_max_o    (nrm_exp_max),
    .nrm_sign_i       (nrm_sign),
    .nrm_sum_i        (nrm_sum),
    .nrm_exp_i        (nrm_exp),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_sign_o       (out_sign),
    .out_mant_o       (out_mant),
    .out_exp_o        (out_exp),
    .out_zero_o       (out_zero),
    .out_ovf_o        (out_ovf)
  );

  // Normalizer: 11-bit mantissa with the leading one at bit 10, exponent adjusted to match.
  function automatic logic [18:0] norm_model(input int a, input int e);
    int mag, p, mi, xi;
    logic [10:0] m;
    logic [6:0]  x;
    mag = (a < 0) ? -a : a;
    if (mag == 0) return '0;
    p = 0;
    for (int i = 0; i < 21; i++) if (mag[i]) p = i;
    mi = (p >= 10) ? (mag >> (p - 10)) : (mag << (10 - p));
    xi = e + p - 10;
    m  = mi[10:0];
    x  = xi[6:0];
    return {(a < 0), m, x};
  endfunction

  always_comb nrm_word = norm_model(int'($signed(nrm_signed_sum)), int'($signed(nrm_exp_max)));
  assign {nrm_sign, nrm_sum, nrm_exp} = nrm_word;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] tp [8];
  logic [5:0]  te [8];
  int          tn;
  int          macc, me;
  bit          movf;
  logic [10:0] got_mant;
  logic [6:0]  got_exp;
  logic        got_zero, got_ovf, got_sign;
  logic [19:0] got_sum;
  logic [5:0]  got_emax;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_term(input int i);
    int pi, ei, d, a, b, s;
    int mask;
    mask = 'hFFFFF;
    pi = int'($signed(tp[i]));
    ei = int'($signed(te[i]));
    if (i == 0) begin
      macc = pi;
      me   = ei;
      movf = 1'b0;
      return;
    end
    d = ei - me;
    if (d > 0) begin
      a  = macc >>> ((d > 31) ? 31 : d);
      b  = pi;
      me = ei;
    end else begin
      a = pi >>> ((-d > 31) ? 31 : -d);
      b = macc;
    end
    s = a + b;
    if (s > 524287 || s < -524288) begin
      movf = 1'b1;
`ifdef MAC_SAT_EN
      s = (s > 0) ? 524287 : -524288;
`else
      s = ((s + 524288) & mask) - 524288;
`endif
    end
    macc = s;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_in_ready"}, 32'(in_ready), 0);
    chk({pfx, "_out_valid"}, 32'(out_valid), 0);
    chk({pfx, "_nrm_sum"}, 32'(nrm_signed_sum), 0);
    chk({pfx, "_nrm_emax"}, 32'(nrm_exp_max), 0);
    chk({pfx, "_out_sign"}, 32'(out_sign), 0);
    chk({pfx, "_out_mant"}, 32'(out_mant), 0);
    chk({pfx, "_out_exp"}, 32'(out_exp), 0);
    chk({pfx, "_out_zero"}, 32'(out_zero), 0);
    chk({pfx, "_out_ovf"}, 32'(out_ovf), 0);
  endtask

  task automatic check_out();
    logic [18:0] ew;
    ew = norm_model(macc, me);
    chk("out_valid", 32'(out_valid), 1);
    chk("in_ready_out", 32'(in_ready), 0);
    chk("out_sign", 32'(out_sign), 32'(ew[18]));
    chk("out_mant", 32'(out_mant), 32'(ew[17:7]));
    chk("out_exp", 32'(out_exp), 32'(ew[6:0]));
    chk("out_zero", 32'(out_zero), 32'(macc == 0));
    chk("out_ovf", 32'(out_ovf), 32'(movf));
    chk("nrm_signed_sum", 32'(nrm_signed_sum), 32'(macc[19:0]));
    chk("nrm_exp_max", 32'(nrm_exp_max), 32'(me[5:0]));
    got_mant = out_mant;
    got_exp  = out_exp;
    got_zero = out_zero;
    got_ovf  = out_ovf;
    got_sign = out_sign;
    got_sum  = nrm_signed_sum;
    got_emax = nrm_exp_max;
  endtask

  // Streams tp/te[0..tn-1], then holds out_ready low for 'hold' cycles; junk drives
  // in_valid during NORM/OUT, which must be ignored.
  task automatic run_dot(input int gap_max, input int hold, input bit junk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    for (int i = 0; i < tn; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
      in_valid = 1'b1;
      in_prod  = tp[i];
      in_exp   = te[i];
      in_last  = (i == tn - 1);
      @(negedge clk);
      if (i == 0) chk("in_ready_accept", 32'(in_ready), 1);
      tick();
      model_term(i);
    end
    in_valid = junk;
    in_last  = junk;
    in_prod  = 20'($urandom);
    @(negedge clk);
    chk("norm_in_ready", 32'(in_ready), 0);
    chk("norm_out_valid", 32'(out_valid), 0);
    tick();
    for (int k = 0; k <= hold; k++) begin
      out_ready = (k == hold);
      @(negedge clk);
      check_out();
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 0);
  endtask

  initial begin
    int v, w, r;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_prod   = '0;
    in_exp    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_zero("rst");
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);

    // T1
    tn = 2; tp[0] = 20'd1024; te[0] = 6'd0; tp[1] = 20'd1024; te[1] = 6'd0;
    run_dot(0, 0, 1'b0);
    chk("t1_sum", 32'(got_sum), 2048);
    chk("t1_mant", 32'(got_mant), 'h400);
    chk("t1_exp", 32'(got_exp), 1);
    chk("t1_sign", 32'(got_sign), 0);
    // T2
    tn = 2; tp[0] = 20'd1024; te[0] = 6'd2; tp[1] = 20'd1024; te[1] = 6'd0;
    run_dot(0, 0, 1'b0);
    chk("t2_sum", 32'(got_sum), 1280);
    chk("t2_emax", 32'(got_emax), 2);
    chk("t2_mant", 32'(got_mant), 'h500);
    chk("t2_exp", 32'(got_exp), 2);
    // T3
    tn = 2; tp[0] = 20'd1024; te[0] = 6'd0; tp[1] = 20'd1024; te[1] = 6'd3;
    run_dot(0, 0, 1'b0);
    chk("t3_sum", 32'(got_sum), 1152);
    chk("t3_emax", 32'(got_emax), 3);
    // T4
    tn = 2; tp[0] = 20'hFFC00; te[0] = 6'd0; tp[1] = 20'd1024; te[1] = 6'd0;
    run_dot(0, 0, 1'b0);
    chk("t4_zero", 32'(got_zero), 1);
    chk("t4_mant", 32'(got_mant), 0);
    // T5
    tn = 2; tp[0] = 20'h40000; te[0] = 6'd0; tp[1] = 20'h40000; te[1] = 6'd0;
    run_dot(0, 0, 1'b0);
    chk("t5_ovf", 32'(got_ovf), 1);
`ifdef MAC_SAT_EN
    chk("t5_sum", 32'(got_sum), 'h7FFFF);
`else
    chk("t5_sum", 32'(got_sum), 'h80000);
`endif
    // T6: long back-pressure with ignored input traffic, then reset mid-ACCUM
    tn = 3; tp[0] = 20'd300; te[0] = 6'd1; tp[1] = 20'hFFFB3; te[1] = 6'd0;
    tp[2] = 20'd5000; te[2] = 6'd2;
    run_dot(1, 5, 1'b1);
    tick();
    in_valid = 1'b1; in_prod = 20'd1234; in_exp = 6'd2; in_last = 1'b0;
    tick();
    in_prod = 20'd55;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_zero("rst_mid");
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 1);
    tn = 1; tp[0] = 20'hFF000; te[0] = 6'h3C;
    run_dot(0, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      tn = $urandom_range(1, 6);
      for (int i = 0; i < tn; i++) begin
        r = $urandom_range(0, 9);
        if (r < 2) v = int'($urandom);
        else v = int'($urandom_range(0, 8191)) - 4096;
        if (r == 2) w = ($urandom_range(0, 1) == 1) ? 31 : -32;
        else w = int'($urandom_range(0, 16)) - 8;
        tp[i] = v[19:0];
        te[i] = w[5:0];
      end
      run_dot(2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
